mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N_REQ cache requesters.
// One transaction in flight: IDLE -> ISSUE (until m_ready or timeout) -> DONE.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            rq_valid,
    input  logic [N_REQ-1:0]            rq_rw,
    input  logic [N_REQ*ADDR_WIDTH-1:0] rq_addr,
    input  logic [N_REQ*WORD_WIDTH-1:0] rq_wdata,
    output logic [N_REQ-1:0]            rq_done,
    output logic [WORD_WIDTH-1:0]       rq_rdata,
    output logic                        m_valid,
    output logic                        m_rw,
    output logic [ADDR_WIDTH-1:0]       m_addr,
    output logic [WORD_WIDTH-1:0]       m_wdata,
    input  logic                        m_ready,
    input  logic [WORD_WIDTH-1:0]       m_rdata,
    output logic [1:0]                  grant_id,
    output logic                        err
);

    localparam int unsigned GW = 2;
    localparam int unsigned CW = 8;
    localparam logic [GW-1:0] GRANT_RST = GW'(N_REQ - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_start;
    logic                  w_complete;
    logic                  w_expire;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         w_winner;
    logic                  w_found;
    logic [3:0]            w_vld;
    logic [2:0]            w_sum;
    logic                  w_sel_rw;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [WORD_WIDTH-1:0] w_sel_wdata;
    logic [CW-1:0]         r_wait;
    logic                  r_m_valid;
    logic                  r_m_rw;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [WORD_WIDTH-1:0] r_m_wdata;
    logic [N_REQ-1:0]      r_done;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_err;

    // Zero-padding to four slots keeps indices >= N_REQ permanently invalid.
    assign w_vld = 4'(rq_valid);

    // Round-robin search starting just after the last grant.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_sum    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_sum = 3'(r_grant) + 3'(k);
            if (w_sum >= 3'(N_REQ)) begin
                w_sum = w_sum - 3'(N_REQ);
            end
            if (!w_found && w_vld[w_sum[1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[1:0];
            end
        end
    end

    // Select the winner's request fields.
    always_comb begin
        w_sel_rw    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == GW'(i)) begin
                w_sel_rw    = rq_rw[i];
                w_sel_addr  = rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = rq_wdata[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // m_ready wins over expiry when both land in the same cycle.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        w_expire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next  = S_ISSUE;
                    w_start = 1'b1;
                end
            end
            S_ISSUE: begin
                if (m_ready) begin
                    w_complete = 1'b1;
                    w_next     = S_DONE;
                end else if (r_wait == WAIT_LAST) begin
                    w_expire = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant   <= GRANT_RST;
            r_wait    <= '0;
            r_m_valid <= 1'b0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_start) begin
                r_grant   <= w_winner;
                r_wait    <= '0;
                r_m_valid <= 1'b1;
                r_m_rw    <= w_sel_rw;
                r_m_addr  <= w_sel_addr;
                r_m_wdata <= w_sel_wdata;
            end else if (r_state == S_ISSUE && !m_ready) begin
                r_wait <= r_wait + CW'(1);
            end
            if (w_complete || w_expire) begin
                r_m_valid <= 1'b0;
                r_done    <= N_REQ'(1) << r_grant;
                r_rdata   <= w_complete ? m_rdata : '0;
            end
            if (w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_rw     = r_m_rw;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign rq_done  = r_done;
    assign rq_rdata = r_rdata;
    assign grant_id = r_grant;
    assign err      = r_err;

endmodule
